pipeline_hazard_ctrl: RTL and testbench

Stall/flush sequencer for the front end of the pipeline.
- Produces the update enables for the fetch and readreg pipeline registers.
- Produces a bubble strobe that forces the readreg control input to zero, and a flush strobe.
- Detects load-use hazards between the decode instruction and the load sitting in readreg.
- Honours memory-stage holds and branch redirects, and counts front-end stall cycles for performance debug.

---
 rtl/pipeline_hazard_ctrl.sv | 98 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: front-end stall/flush sequencer with load-use detection and stall counter
module pipeline_hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 2,
    parameter int CNT_W             = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [2:0]       dec_num_Rm,
    input  logic [2:0]       dec_num_Rn,
    input  logic [2:0]       dec_used_RmRnRd,
    input  logic             rr_loads,
    input  logic [2:0]       rr_num_Rd,
    input  logic             mem_busy,
    input  logic             branch_taken,
    output logic             update_fetch,
    output logic             update_readreg,
    output logic             bubble,
    output logic             flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count
);
    typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, MEM_WAIT = 2'd2, FLUSH = 2'd3} state_t;
    // action vectors are {update_fetch, update_readreg, bubble, flush}
    localparam logic [3:0] A_GO   = 4'b1100;
    localparam logic [3:0] A_HOLD = 4'b0000;
    localparam logic [3:0] A_BUB  = 4'b0110;
    localparam logic [3:0] A_FL   = 4'b1111;
    localparam logic [3:0] LS_RELOAD = 4'(LOAD_STALL_CYCLES - 1);
    localparam logic [3:0] FL_RELOAD = 4'(FLUSH_CYCLES - 1);
    state_t           r_state, w_state_nx;
    logic [3:0]       r_cnt, w_cnt_nx;
    logic [3:0]       w_act;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_hazard;
    assign w_hazard = dec_valid & rr_loads &
                      ((dec_used_RmRnRd[2] & (dec_num_Rm == rr_num_Rd)) |
                       (dec_used_RmRnRd[1] & (dec_num_Rn == rr_num_Rd)));
    // next state, counter and action; MEM_WAIT without mem_busy falls through to RUN evaluation
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_act      = A_GO;
        if (r_state == FLUSH) begin
            if (mem_busy) begin
                w_act = A_HOLD;
            end else if (branch_taken) begin
                w_act      = A_FL;
                w_state_nx = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                w_cnt_nx   = (FLUSH_CYCLES == 1) ? 4'd0 : FL_RELOAD;
            end else begin
                w_act      = A_FL;
                w_state_nx = (r_cnt == 4'd1) ? RUN : FLUSH;
                w_cnt_nx   = r_cnt - 4'd1;
            end
        end else if (mem_busy) begin
            w_act      = A_HOLD;
            w_state_nx = MEM_WAIT;
            w_cnt_nx   = 4'd0;
        end else if (branch_taken) begin
            w_act      = A_FL;
            w_state_nx = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
            w_cnt_nx   = (FLUSH_CYCLES == 1) ? 4'd0 : FL_RELOAD;
        end else if (r_state == LOAD_STALL) begin
            w_act      = A_BUB;
            w_state_nx = (r_cnt == 4'd1) ? RUN : LOAD_STALL;
            w_cnt_nx   = r_cnt - 4'd1;
        end else if (w_hazard) begin
            w_act      = A_BUB;
            w_state_nx = (LOAD_STALL_CYCLES == 1) ? RUN : LOAD_STALL;
            w_cnt_nx   = (LOAD_STALL_CYCLES == 1) ? 4'd0 : LS_RELOAD;
        end else begin
            w_state_nx = RUN;
            w_cnt_nx   = 4'd0;
        end
    end
    // reset forces a frozen front end with a NOP into readreg
    assign update_fetch   = ~rst & w_act[3];
    assign update_readreg = ~rst & w_act[2];
    assign bubble         =  rst | w_act[1];
    assign flush          = ~rst & w_act[0];
    assign state          = r_state;
    assign stall_count    = r_stall_count;
    // state, counter and saturating stall counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_cnt         <= 4'd0;
            r_stall_count <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            if (!update_fetch && r_stall_count != '1)
                r_stall_count <= r_stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven and directed checks of the hazard sequencer
module tb_pipeline_hazard_ctrl;
    logic       clk = 0;
    logic       rst = 1;
    logic       dv = 0, ld = 0, mb = 0, br = 0;
    logic [2:0] rm = 0, rn = 0, used = 0, rd = 0;
    logic       a_uf, a_ur, a_bub, a_fl;
    logic [1:0] a_st;
    logic [7:0] a_sc;
    logic       b_uf, b_ur, b_bub, b_fl;
    logic [1:0] b_st;
    logic [3:0] b_sc;
    int n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_a (
        .clk(clk), .rst(rst), .dec_valid(dv), .dec_num_Rm(rm), .dec_num_Rn(rn),
        .dec_used_RmRnRd(used), .rr_loads(ld), .rr_num_Rd(rd), .mem_busy(mb),
        .branch_taken(br), .update_fetch(a_uf), .update_readreg(a_ur), .bubble(a_bub),
        .flush(a_fl), .state(a_st), .stall_count(a_sc)
    );

    pipeline_hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(2), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .dec_valid(dv), .dec_num_Rm(rm), .dec_num_Rn(rn),
        .dec_used_RmRnRd(used), .rr_loads(ld), .rr_num_Rd(rd), .mem_busy(mb),
        .branch_taken(br), .update_fetch(b_uf), .update_readreg(b_ur), .bubble(b_bub),
        .flush(b_fl), .state(b_st), .stall_count(b_sc)
    );

    typedef struct {
        logic       rst, dv;
        logic [2:0] rm, rn, used;
        logic       ld;
        logic [2:0] rd;
        logic       mb, br;
        logic [3:0] act;
        logic [1:0] st;
        logic [7:0] sc;
    } vec_t;

    localparam logic [3:0] GO = 4'b1100, HO = 4'b0000, BU = 4'b0110, FL = 4'b1111, RS = 4'b0010;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        rst = 0; dv = 1; rm = 0; rn = 0; used = 0; ld = 0; rd = 0; mb = 0; br = 0;
    endtask

    task automatic hazard();
        ld = 1; rd = 3; rn = 3; used = 3'b010;
    endtask

    vec_t v[36];

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        v[0]  = '{1,1,0,0,3'b000,0,0,0,0,RS,0,0};
        v[1]  = '{1,1,0,0,3'b000,0,0,0,0,RS,0,0};
        v[2]  = '{0,1,0,0,3'b000,0,0,0,0,GO,0,0};
        v[3]  = '{0,1,0,0,3'b000,0,0,0,0,GO,0,0};
        v[4]  = '{0,1,0,3,3'b010,1,3,0,0,BU,0,0};
        v[5]  = '{0,1,0,0,3'b000,0,0,0,0,GO,0,1};
        v[6]  = '{0,1,0,3,3'b001,1,3,0,0,GO,0,1};
        v[7]  = '{0,1,5,0,3'b100,1,5,0,0,BU,0,1};
        v[8]  = '{0,0,5,0,3'b100,1,5,0,0,GO,0,2};
        v[9]  = '{0,1,0,0,3'b100,1,0,0,0,BU,0,2};
        v[10] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,3};
        v[11] = '{0,1,0,0,3'b000,0,0,0,1,FL,0,3};
        v[12] = '{0,1,0,0,3'b000,0,0,0,0,FL,3,3};
        v[13] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,3};
        v[14] = '{0,1,0,0,3'b000,0,0,0,1,FL,0,3};
        v[15] = '{0,1,0,0,3'b000,0,0,0,1,FL,3,3};
        v[16] = '{0,1,0,0,3'b000,0,0,0,0,FL,3,3};
        v[17] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,3};
        v[18] = '{0,1,0,3,3'b010,1,3,1,1,HO,0,3};
        v[19] = '{0,1,0,3,3'b010,1,3,1,1,HO,2,4};
        v[20] = '{0,1,0,3,3'b010,1,3,1,1,HO,2,5};
        v[21] = '{0,1,0,3,3'b010,1,3,1,1,HO,2,6};
        v[22] = '{0,1,0,3,3'b010,1,3,0,1,FL,2,7};
        v[23] = '{0,1,0,0,3'b000,0,0,0,0,FL,3,7};
        v[24] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,7};
        v[25] = '{0,1,0,0,3'b000,0,0,0,1,FL,0,7};
        v[26] = '{0,1,0,0,3'b000,0,0,1,0,HO,3,7};
        v[27] = '{0,1,0,0,3'b000,0,0,0,0,FL,3,8};
        v[28] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,8};
        v[29] = '{0,1,0,3,3'b010,1,3,1,0,HO,0,8};
        v[30] = '{0,1,0,3,3'b010,1,3,0,0,BU,2,9};
        v[31] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,10};
        v[32] = '{0,1,0,0,3'b000,0,0,0,1,FL,0,10};
        v[33] = '{1,1,0,0,3'b000,0,0,0,1,RS,3,10};
        v[34] = '{0,1,0,0,3'b000,0,0,0,0,GO,0,0};
        v[35] = '{0,1,0,3,3'b010,1,4,0,0,GO,0,0};

        rst = 1; dv = 1;
        tick();
        for (int i = 0; i < 36; i++) begin
            rst = v[i].rst; dv = v[i].dv; rm = v[i].rm; rn = v[i].rn; used = v[i].used;
            ld = v[i].ld; rd = v[i].rd; mb = v[i].mb; br = v[i].br;
            #2;
            chk($sformatf("vec%0d_act", i), {a_uf, a_ur, a_bub, a_fl}, v[i].act);
            chk($sformatf("vec%0d_state", i), a_st, v[i].st);
            chk($sformatf("vec%0d_stall", i), a_sc, v[i].sc);
            tick();
        end

        defaults(); rst = 1;
        tick();
        defaults(); hazard();
        #2;
        chk("ls3_c1_act", {b_uf, b_ur, b_bub, b_fl}, BU);
        chk("ls3_c1_state", b_st, 0);
        tick();
        defaults();
        #2;
        chk("ls3_c2_act", {b_uf, b_ur, b_bub, b_fl}, BU);
        chk("ls3_c2_state", b_st, 1);
        tick();
        #2;
        chk("ls3_c3_act", {b_uf, b_ur, b_bub, b_fl}, BU);
        chk("ls3_c3_state", b_st, 1);
        tick();
        #2;
        chk("ls3_c4_act", {b_uf, b_ur, b_bub, b_fl}, GO);
        chk("ls3_c4_state", b_st, 0);
        chk("ls3_stall", b_sc, 3);
        tick();
        used = 3'b001; ld = 1; rd = 3; rn = 3;
        #2;
        chk("ls3_rd_only_act", {b_uf, b_ur, b_bub, b_fl}, GO);
        tick();

        defaults(); hazard();
        #2;
        chk("rst_ls_c1_act", {b_uf, b_ur, b_bub, b_fl}, BU);
        tick();
        defaults(); rst = 1;
        #2;
        chk("rst_ls_forced", {b_uf, b_ur, b_bub, b_fl}, RS);
        chk("rst_ls_state_before", b_st, 1);
        tick();
        defaults();
        #2;
        chk("rst_ls_state_after", b_st, 0);
        chk("rst_ls_stall_after", b_sc, 0);
        chk("rst_ls_no_bubble", {b_uf, b_ur, b_bub, b_fl}, GO);
        tick();

        defaults(); mb = 1;
        for (int i = 0; i < 20; i++) begin
            #2;
            if (i == 16) chk("sat_c16", b_sc, 15);
            tick();
        end
        #2;
        chk("sat_end", b_sc, 15);
        chk("sat_state", b_st, 2);
        defaults();
        tick();
        #2;
        chk("sat_after_go", b_sc, 15);
        chk("sat_after_go_act", {b_uf, b_ur, b_bub, b_fl}, GO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
